// File: rtl/cv32e40p_lsu_if.sv
// OBI data-bus bundle between the load/store unit and the data memory.
interface cv32e40p_lsu_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic [5:0]  data_atop_o;

    // LSU side issues requests and consumes responses.
    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, data_atop_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    // Memory side grants requests and returns responses.
    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, data_atop_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/cv32e40p_lsu.sv
// Load/store unit: address generation, byte enables, store-data rotation, outstanding
// transaction tracking and load-data alignment/extension between EX and the OBI bus.
module cv32e40p_lsu #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cv32e40p_lsu_if.master        obi,
    input  logic                  data_we_ex_i,
    input  logic [1:0]            data_type_ex_i,
    input  logic [31:0]           data_wdata_ex_i,
    input  logic [1:0]            data_reg_offset_ex_i,
    input  logic                  data_load_event_ex_i,
    input  logic [1:0]            data_sign_ext_ex_i,
    output logic [31:0]           data_rdata_ex_o,
    input  logic                  data_req_ex_i,
    input  logic [31:0]           operand_a_ex_i,
    input  logic [31:0]           operand_b_ex_i,
    input  logic                  addr_useincr_ex_i,
    input  logic                  data_misaligned_ex_i,
    input  logic [5:0]            data_atop_ex_i,
    output logic                  data_misaligned_o,
    output logic                  p_elw_start_o,
    output logic                  p_elw_finish_o,
    output logic                  lsu_ready_ex_o,
    output logic                  lsu_ready_wb_o,
    output logic                  busy_o
);

    localparam logic [1:0] MaxCnt = 2'(DEPTH);

    logic [31:0] addr;
    logic [1:0]  off;
    logic        req;
    logic        issue;
    logic        resp;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        we_q;
    logic [1:0]  type_q;
    logic [1:0]  rdata_offset_q;
    logic [1:0]  sign_ext_q;
    logic        load_event_q;
    logic [31:0] rdata_q;
    logic        ctrl_update;

    logic [31:0] rd;
    logic [31:0] word_val;
    logic [15:0] half_val;
    logic [7:0]  byte_val;

    assign addr  = addr_useincr_ex_i ? (operand_a_ex_i + operand_b_ex_i) : operand_a_ex_i;
    assign off   = addr[1:0];
    assign req   = data_req_ex_i && (cnt_q < MaxCnt);
    assign issue = req && obi.data_gnt_i;
    // A response with nothing outstanding (e.g. straggler after reset) is ignored.
    assign resp  = obi.data_rvalid_i && (cnt_q != 2'd0);
    assign rd    = obi.data_rdata_i;

    assign obi.data_req_o   = req;
    assign obi.data_addr_o  = addr;
    assign obi.data_we_o    = data_we_ex_i;
    assign obi.data_be_o    = be;
    assign obi.data_wdata_o = wdata;
    assign obi.data_atop_o  = data_atop_ex_i;

    // Byte enables: first transfer covers off..3, the split second transfer the spill-over.
    always_comb begin
        be = 4'b0000;
        case (data_type_ex_i)
            2'b00: begin
                if (data_misaligned_ex_i) begin
                    case (off)
                        2'd1:    be = 4'b0001;
                        2'd2:    be = 4'b0011;
                        2'd3:    be = 4'b0111;
                        default: be = 4'b0000;
                    endcase
                end else begin
                    case (off)
                        2'd0:    be = 4'b1111;
                        2'd1:    be = 4'b1110;
                        2'd2:    be = 4'b1100;
                        default: be = 4'b1000;
                    endcase
                end
            end
            2'b01: begin
                if (data_misaligned_ex_i) begin
                    be = 4'b0001;
                end else begin
                    case (off)
                        2'd0:    be = 4'b0011;
                        2'd1:    be = 4'b0110;
                        2'd2:    be = 4'b1100;
                        default: be = 4'b1000;
                    endcase
                end
            end
            default: be = 4'b0001 << off;
        endcase
    end

    // Store data rotated left by whole bytes so each byte lands on its lane.
    always_comb begin
        case (data_reg_offset_ex_i)
            2'd0:    wdata = data_wdata_ex_i;
            2'd1:    wdata = {data_wdata_ex_i[23:0], data_wdata_ex_i[31:24]};
            2'd2:    wdata = {data_wdata_ex_i[15:0], data_wdata_ex_i[31:16]};
            default: wdata = {data_wdata_ex_i[7:0], data_wdata_ex_i[31:8]};
        endcase
    end

    assign data_misaligned_o = data_req_ex_i && !data_misaligned_ex_i &&
                               (((data_type_ex_i == 2'b00) && (off != 2'd0)) ||
                                ((data_type_ex_i == 2'b01) && (off == 2'd3)));

    // Outstanding-transaction count next state.
    always_comb begin
        cnt_d = cnt_q;
        case ({issue, resp})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // EX may only advance once the bus has room for its transaction to be tracked.
    always_comb begin
        lsu_ready_ex_o = 1'b1;
        if (data_req_ex_i) begin
            case (cnt_q)
                2'd0:    lsu_ready_ex_o = req && obi.data_gnt_i;
                2'd1:    lsu_ready_ex_o = obi.data_rvalid_i && req && obi.data_gnt_i;
                2'd2:    lsu_ready_ex_o = obi.data_rvalid_i;
                default: lsu_ready_ex_o = 1'b0;
            endcase
        end
    end

    assign lsu_ready_wb_o = (cnt_q == 2'd0) ? 1'b1 : obi.data_rvalid_i;
    assign busy_o         = (cnt_q != 2'd0) || req;
    assign ctrl_update    = data_req_ex_i && lsu_ready_ex_o;

    // Counter and per-transaction control captured for the returning response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= 2'd0;
            we_q           <= 1'b0;
            type_q         <= 2'b00;
            rdata_offset_q <= 2'd0;
            sign_ext_q     <= 2'b00;
            load_event_q   <= 1'b0;
            rdata_q        <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
            if (ctrl_update) begin
                we_q           <= data_we_ex_i;
                type_q         <= data_type_ex_i;
                rdata_offset_q <= off;
                sign_ext_q     <= data_sign_ext_ex_i;
                load_event_q   <= data_load_event_ex_i;
            end
            // Keeps the first half of a split load for merging with the second.
            if (obi.data_rvalid_i && !we_q) begin
                rdata_q <= obi.data_rdata_i;
            end
        end
    end

    // Align the returned word; split accesses take their low bytes from rdata_q.
    always_comb begin
        case (rdata_offset_q)
            2'd0: begin
                word_val = rd;
                half_val = rd[15:0];
                byte_val = rd[7:0];
            end
            2'd1: begin
                word_val = {rd[7:0], rdata_q[31:8]};
                half_val = rd[23:8];
                byte_val = rd[15:8];
            end
            2'd2: begin
                word_val = {rd[15:0], rdata_q[31:16]};
                half_val = rd[31:16];
                byte_val = rd[23:16];
            end
            default: begin
                word_val = {rd[23:0], rdata_q[31:24]};
                half_val = {rd[7:0], rdata_q[31:24]};
                byte_val = rd[31:24];
            end
        endcase
    end

    // Extend half/byte results: 01 sign, 10 ones, otherwise zero.
    always_comb begin
        case (type_q)
            2'b00: data_rdata_ex_o = word_val;
            2'b01: begin
                case (sign_ext_q)
                    2'b01:   data_rdata_ex_o = {{16{half_val[15]}}, half_val};
                    2'b10:   data_rdata_ex_o = {16'hFFFF, half_val};
                    default: data_rdata_ex_o = {16'h0000, half_val};
                endcase
            end
            default: begin
                case (sign_ext_q)
                    2'b01:   data_rdata_ex_o = {{24{byte_val[7]}}, byte_val};
                    2'b10:   data_rdata_ex_o = {24'hFFFFFF, byte_val};
                    default: data_rdata_ex_o = {24'h000000, byte_val};
                endcase
            end
        endcase
    end

    assign p_elw_start_o  = req && data_load_event_ex_i;
    assign p_elw_finish_o = obi.data_rvalid_i && load_event_q && !we_q;

endmodule

// File: tb/tb_cv32e40p_lsu.sv
// Scoreboard bench for cv32e40p_lsu: a random OBI slave backed by a word memory, a driver
// issuing loads/stores and a monitor comparing write-back results against a byte-level model.
module tb_cv32e40p_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cv32e40p_lsu_if obi ();

    logic        data_we_ex_i = 1'b0;
    logic [1:0]  data_type_ex_i = 2'b00;
    logic [31:0] data_wdata_ex_i = 32'h0;
    logic [1:0]  data_reg_offset_ex_i = 2'd0;
    logic        data_load_event_ex_i = 1'b0;
    logic [1:0]  data_sign_ext_ex_i = 2'b00;
    logic [31:0] data_rdata_ex_o;
    logic        data_req_ex_i = 1'b0;
    logic [31:0] operand_a_ex_i = 32'h0;
    logic [31:0] operand_b_ex_i = 32'h0;
    logic        addr_useincr_ex_i = 1'b0;
    logic        data_misaligned_ex_i = 1'b0;
    logic [5:0]  data_atop_ex_i = 6'h0;
    logic        data_misaligned_o;
    logic        p_elw_start_o;
    logic        p_elw_finish_o;
    logic        lsu_ready_ex_o;
    logic        lsu_ready_wb_o;
    logic        busy_o;

    logic        s_gnt = 1'b0;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    assign obi.data_gnt_i    = s_gnt;
    assign obi.data_rvalid_i = s_rvalid;
    assign obi.data_rdata_i  = s_rdata;

    cv32e40p_lsu #(.DEPTH(2)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .obi                  (obi),
        .data_we_ex_i         (data_we_ex_i),
        .data_type_ex_i       (data_type_ex_i),
        .data_wdata_ex_i      (data_wdata_ex_i),
        .data_reg_offset_ex_i (data_reg_offset_ex_i),
        .data_load_event_ex_i (data_load_event_ex_i),
        .data_sign_ext_ex_i   (data_sign_ext_ex_i),
        .data_rdata_ex_o      (data_rdata_ex_o),
        .data_req_ex_i        (data_req_ex_i),
        .operand_a_ex_i       (operand_a_ex_i),
        .operand_b_ex_i       (operand_b_ex_i),
        .addr_useincr_ex_i    (addr_useincr_ex_i),
        .data_misaligned_ex_i (data_misaligned_ex_i),
        .data_atop_ex_i       (data_atop_ex_i),
        .data_misaligned_o    (data_misaligned_o),
        .p_elw_start_o        (p_elw_start_o),
        .p_elw_finish_o       (p_elw_finish_o),
        .lsu_ready_ex_o       (lsu_ready_ex_o),
        .lsu_ready_wb_o       (lsu_ready_wb_o),
        .busy_o               (busy_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
        logic        fin;
    } exp_t;

    logic [31:0] mem_w [0:127];
    exp_t        sb_q[$];
    logic [31:0] resp_q[$];
    bit          force_mode = 1'b0;
    bit          f_gnt = 1'b0;
    bit          f_rvalid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // Byte-level model: little-endian bytes from addr, then extension.
    function automatic logic [31:0] load_ref(input logic [31:0] addr, input logic [1:0] typ,
                                             input logic [1:0] sext);
        int          size;
        logic [31:0] v;
        logic [31:0] w;
        logic [31:0] a;
        logic [31:0] mask;
        size = (typ == 2'b00) ? 4 : (typ == 2'b01) ? 2 : 1;
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
            a = addr + 32'(i);
            w = mem_w[a[8:2]] >> (8 * a[1:0]);
            v = v | ((w & 32'hFF) << (8 * i));
        end
        if (size < 4) begin
            mask = (size == 2) ? 32'h0000FFFF : 32'h000000FF;
            if (sext == 2'b10 || (sext == 2'b01 && v[8*size-1])) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [3:0] be_ref(input logic [1:0] typ, input logic [1:0] off,
                                          input bit mis);
        int         size, lo, hi;
        logic [3:0] b;
        size = (typ == 2'b00) ? 4 : (typ == 2'b01) ? 2 : 1;
        b = 4'b0000;
        if (!mis) begin
            lo = int'(off);
            hi = int'(off) + size - 1;
            if (hi > 3) hi = 3;
        end else begin
            lo = 0;
            hi = int'(off) + size - 5;
        end
        for (int i = 0; i < 4; i++) if (i >= lo && i <= hi) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] rot_ref(input logic [31:0] w, input logic [1:0] ro);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*((i + int'(ro)) % 4) +: 8] = w[8*i +: 8];
        return r;
    endfunction

    // Slave drive: responses in order, grant only where the LSU can take it.
    always @(posedge clk) begin : slave_drv
        logic rv;
        #1;
        if (force_mode) begin
            s_gnt    = f_gnt;
            s_rvalid = f_rvalid;
            s_rdata  = 32'h0;
        end else begin
            rv       = (resp_q.size() != 0) && ($urandom_range(0, 2) != 0);
            s_rvalid = rv;
            s_rdata  = rv ? resp_q[0] : $urandom;
            s_gnt    = ($urandom_range(0, 3) != 0) && ((resp_q.size() == 0) || rv);
        end
    end

    // Monitor: retire responses against the scoreboard, record newly granted requests.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!force_mode && rst_n) begin
            if (obi.data_rvalid_i && sb_q.size() != 0) begin
                void'(resp_q.pop_front());
                e = sb_q.pop_front();
                check("wb_ready", {31'h0, lsu_ready_wb_o}, 32'h1);
                check("elw_finish", {31'h0, p_elw_finish_o}, {31'h0, e.fin});
                if (e.chk) check("load_data", data_rdata_ex_o, e.data);
            end
            if (obi.data_req_o && obi.data_gnt_i)
                resp_q.push_back(obi.data_we_o ? 32'h0 : mem_w[obi.data_addr_o[8:2]]);
        end
    end

    task automatic do_op(input bit we, input logic [1:0] typ, input logic [31:0] addr,
                         input logic [1:0] sext, input logic [31:0] wd, input logic [1:0] ro,
                         input bit elw, input bit mis_ex, input bit chk,
                         input logic [31:0] expv);
        bit   done;
        logic exp_mis;
        logic [5:0] atop;
        @(posedge clk);
        #1;
        atop = 6'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            operand_a_ex_i    = $urandom;
            operand_b_ex_i    = addr - operand_a_ex_i;
            addr_useincr_ex_i = 1'b1;
        end else begin
            operand_a_ex_i    = addr;
            operand_b_ex_i    = $urandom;
            addr_useincr_ex_i = 1'b0;
        end
        data_req_ex_i        = 1'b1;
        data_we_ex_i         = we;
        data_type_ex_i       = typ;
        data_wdata_ex_i      = wd;
        data_reg_offset_ex_i = ro;
        data_load_event_ex_i = elw;
        data_sign_ext_ex_i   = sext;
        data_misaligned_ex_i = mis_ex;
        data_atop_ex_i       = atop;
        exp_mis = !mis_ex && (((typ == 2'b00) && (addr[1:0] != 2'd0)) ||
                              ((typ == 2'b01) && (addr[1:0] == 2'd3)));
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("addr", obi.data_addr_o, addr);
                check("be", {28'h0, obi.data_be_o}, {28'h0, be_ref(typ, addr[1:0], mis_ex)});
                check("we", {31'h0, obi.data_we_o}, {31'h0, we});
                check("wdata", obi.data_wdata_o, rot_ref(wd, ro));
                check("atop", {26'h0, obi.data_atop_o}, {26'h0, atop});
                check("misaligned", {31'h0, data_misaligned_o}, {31'h0, exp_mis});
                check("req_o", {31'h0, obi.data_req_o}, 32'h1);
                check("elw_start", {31'h0, p_elw_start_o}, {31'h0, elw});
                check("busy", {31'h0, busy_o}, 32'h1);
            end
            if (obi.data_req_o && obi.data_gnt_i) begin
                check("ready_ex", {31'h0, lsu_ready_ex_o}, 32'h1);
                sb_q.push_back('{chk: chk, data: expv, fin: elw && !we});
                done = 1'b1;
            end
        end
        if (!done) timeout("issue");
    endtask

    // Full access, split into two transfers when it crosses a word boundary.
    task automatic access(input bit we, input logic [1:0] typ, input logic [31:0] addr,
                          input logic [1:0] sext, input logic [31:0] wd, input logic [1:0] ro,
                          input bit elw);
        bit mis;
        mis = ((typ == 2'b00) && (addr[1:0] != 2'd0)) || ((typ == 2'b01) && (addr[1:0] == 2'd3));
        if (!mis) begin
            do_op(we, typ, addr, sext, wd, ro, elw, 1'b0, !we, load_ref(addr, typ, sext));
        end else begin
            do_op(we, typ, addr, sext, wd, ro, elw, 1'b0, 1'b0, 32'h0);
            do_op(we, typ, addr + 32'd4, sext, wd, ro, elw, 1'b1, !we, load_ref(addr, typ, sext));
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        data_req_ex_i = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        bit ok;
        idle(0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) ok = 1'b1;
        end
        if (!ok) timeout("drain");
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_w[i] = $urandom;
        mem_w[32'h104 >> 2] = 32'hDEADBEEF;
        mem_w[32'h40 >> 2]  = 32'h0080FF00;
        mem_w[32'h80 >> 2]  = 32'h44332211;
        mem_w[32'h84 >> 2]  = 32'h88776655;

        // Reset state with no request pending.
        #3;
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_req_o", {31'h0, obi.data_req_o}, 32'h0);
        check("rst_ready_ex", {31'h0, lsu_ready_ex_o}, 32'h1);
        check("rst_ready_wb", {31'h0, lsu_ready_wb_o}, 32'h1);
        check("rst_misaligned", {31'h0, data_misaligned_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        access(1'b0, 2'b00, 32'h104, 2'b00, 32'h0, 2'd0, 1'b0);
        access(1'b1, 2'b10, 32'h103, 2'b00, 32'h000000AB, 2'd3, 1'b0);
        access(1'b0, 2'b01, 32'h41, 2'b01, 32'h0, 2'd0, 1'b1);
        access(1'b0, 2'b01, 32'h41, 2'b00, 32'h0, 2'd0, 1'b0);
        access(1'b0, 2'b00, 32'h82, 2'b00, 32'h0, 2'd0, 1'b0);
        drain();

        // Random loads and stores.
        for (int n = 0; n < 150; n++) begin
            bit         we;
            logic [1:0] typ;
            logic [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            typ  = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 32'h1F0));
            access(we, typ, addr, 2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 3)),
                   !we && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Grant held, no responses: count saturates at two, then async reset mid-transfer.
        @(negedge clk);
        force_mode = 1'b1;
        f_gnt      = 1'b1;
        f_rvalid   = 1'b0;
        @(posedge clk);
        #2;
        operand_a_ex_i       = 32'h40;
        addr_useincr_ex_i    = 1'b0;
        data_we_ex_i         = 1'b0;
        data_type_ex_i       = 2'b00;
        data_misaligned_ex_i = 1'b0;
        data_req_ex_i        = 1'b1;
        @(negedge clk);
        check("sat_ready_ex0", {31'h0, lsu_ready_ex_o}, 32'h1);
        @(negedge clk);
        check("sat_req_o1", {31'h0, obi.data_req_o}, 32'h1);
        check("sat_ready_ex1", {31'h0, lsu_ready_ex_o}, 32'h0);
        @(negedge clk);
        check("sat_req_o2", {31'h0, obi.data_req_o}, 32'h0);
        check("sat_ready_ex2", {31'h0, lsu_ready_ex_o}, 32'h0);
        check("sat_ready_wb2", {31'h0, lsu_ready_wb_o}, 32'h0);
        @(negedge clk);
        check("sat_hold_req_o", {31'h0, obi.data_req_o}, 32'h0);
        #1;
        data_req_ex_i = 1'b0;
        f_gnt         = 1'b0;
        #1;
        check("pre_rst_busy", {31'h0, busy_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        check("mid_rst_ready_wb", {31'h0, lsu_ready_wb_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Straggler response with nothing outstanding must not disturb the count.
        f_rvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("late_rvalid_busy", {31'h0, busy_o}, 32'h0);
        check("late_rvalid_ready_wb", {31'h0, lsu_ready_wb_o}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        force_mode = 1'b0;

        // Normal operation resumes after reset.
        access(1'b0, 2'b00, 32'h104, 2'b00, 32'h0, 2'd0, 1'b1);
        access(1'b0, 2'b10, 32'h107, 2'b01, 32'h0, 2'd0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
